// File: rtl/mini68k_exc_sequencer.sv
// Exception entry sequencer for a small 68000-style core: stacks PC and SR on the
// supervisor stack, fetches the handler vector, then loads PC, SR and SSP.
module mini68k_exc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_req,
  input  logic [7:0]  vector_num,
  input  logic        enter_supervisor,
  output logic        exception_ack,
  input  logic [31:0] cur_pc,
  input  logic [15:0] cur_sr,
  input  logic [31:0] cur_ssp,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  output logic [31:0] new_pc,
  output logic [15:0] new_sr,
  output logic [31:0] new_ssp,
  output logic        pc_load,
  output logic        sr_load,
  output logic        ssp_load,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_PCL = 3'd1,
    PUSH_PCH = 3'd2,
    PUSH_SR  = 3'd3,
    FETCH_VH = 3'd4,
    FETCH_VL = 3'd5,
    LOAD     = 3'd6,
    HALT     = 3'd7
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  vec_r, vec_s;
  logic [31:0] pc_r, pc_s;
  logic [15:0] sr_r, sr_s;
  logic [31:0] ssp_r, ssp_s;
  logic        sup_r, sup_s;
  logic [31:0] fpc_r, fpc_s;
  logic [31:0] vaddr_s;

  logic        bus_req_r, bus_req_s;
  logic        bus_we_r, bus_we_s;
  logic [31:0] bus_addr_r, bus_addr_s;
  logic [15:0] bus_wdata_r, bus_wdata_s;
  logic [15:0] new_sr_r, new_sr_s;
  logic [31:0] new_ssp_r, new_ssp_s;
  logic        load_r, load_s;
  logic        busy_r, busy_s;
  logic        halted_r, halted_s;

  // Interrupt vectors 25..31 map to level 1..7; since 24 has zero low bits the
  // level is simply the vector's low three bits.
  function automatic logic [15:0] entry_sr(input logic [15:0] sr,
                                           input logic [7:0]  vec,
                                           input logic        sup);
    logic [15:0] res;
    res     = sr;
    res[15] = 1'b0;
    res[13] = sr[13] | sup;
    if ((vec >= 8'd25) && (vec <= 8'd31)) begin
      res[10:8] = vec[2:0];
    end else begin
      res[10:8] = sr[10:8];
    end
    return res;
  endfunction

  // Acceptance pulse: only in IDLE, suppressed while reset is asserted.
  always_comb begin
    if (!rst && (state_r == IDLE) && exception_req) begin
      exception_ack = 1'b1;
    end else begin
      exception_ack = 1'b0;
    end
  end

  // Next-state and context-latch logic.
  always_comb begin
    state_s = state_r;
    vec_s   = vec_r;
    pc_s    = pc_r;
    sr_s    = sr_r;
    ssp_s   = ssp_r;
    sup_s   = sup_r;
    fpc_s   = fpc_r;
    case (state_r)
      IDLE: begin
        if (exception_req) begin
          vec_s   = vector_num;
          pc_s    = cur_pc;
          sr_s    = cur_sr;
          ssp_s   = cur_ssp;
          sup_s   = enter_supervisor;
          state_s = PUSH_PCL;
        end else begin
          state_s = IDLE;
        end
      end
      PUSH_PCL, PUSH_PCH, PUSH_SR, FETCH_VH, FETCH_VL: begin
        if (bus_err) begin
          state_s = HALT;
        end else if (bus_ack) begin
          case (state_r)
            PUSH_PCL: state_s = PUSH_PCH;
            PUSH_PCH: state_s = PUSH_SR;
            PUSH_SR:  state_s = FETCH_VH;
            FETCH_VH: begin
              fpc_s[31:16] = bus_rdata;
              state_s      = FETCH_VL;
            end
            FETCH_VL: begin
              fpc_s[15:0] = bus_rdata;
              state_s     = bus_rdata[0] ? HALT : LOAD;
            end
            default:  state_s = HALT;
          endcase
        end else begin
          state_s = state_r;
        end
      end
      LOAD:    state_s = IDLE;
      HALT:    state_s = HALT;
      default: state_s = IDLE;
    endcase
  end

  assign vaddr_s = {22'd0, vec_s, 2'b00};

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    bus_req_s   = 1'b0;
    bus_we_s    = 1'b0;
    bus_addr_s  = 32'd0;
    bus_wdata_s = 16'd0;
    load_s      = 1'b0;
    new_sr_s    = new_sr_r;
    new_ssp_s   = new_ssp_r;
    busy_s      = (state_s != IDLE);
    halted_s    = (state_s == HALT);
    case (state_s)
      PUSH_PCL: begin
        bus_req_s   = 1'b1;
        bus_we_s    = 1'b1;
        bus_addr_s  = ssp_s - 32'd2;
        bus_wdata_s = pc_s[15:0];
      end
      PUSH_PCH: begin
        bus_req_s   = 1'b1;
        bus_we_s    = 1'b1;
        bus_addr_s  = ssp_s - 32'd4;
        bus_wdata_s = pc_s[31:16];
      end
      PUSH_SR: begin
        bus_req_s   = 1'b1;
        bus_we_s    = 1'b1;
        bus_addr_s  = ssp_s - 32'd6;
        bus_wdata_s = sr_s;
      end
      FETCH_VH: begin
        bus_req_s  = 1'b1;
        bus_addr_s = vaddr_s;
      end
      FETCH_VL: begin
        bus_req_s  = 1'b1;
        bus_addr_s = vaddr_s + 32'd2;
      end
      LOAD: begin
        load_s    = 1'b1;
        new_sr_s  = entry_sr(sr_s, vec_s, sup_s);
        new_ssp_s = ssp_s - 32'd6;
      end
      default: begin
        bus_req_s = 1'b0;
      end
    endcase
  end

  // State, latched context and registered outputs; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      vec_r       <= 8'd0;
      pc_r        <= 32'd0;
      sr_r        <= 16'd0;
      ssp_r       <= 32'd0;
      sup_r       <= 1'b0;
      fpc_r       <= 32'd0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 16'd0;
      new_sr_r    <= 16'd0;
      new_ssp_r   <= 32'd0;
      load_r      <= 1'b0;
      busy_r      <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      vec_r       <= vec_s;
      pc_r        <= pc_s;
      sr_r        <= sr_s;
      ssp_r       <= ssp_s;
      sup_r       <= sup_s;
      fpc_r       <= fpc_s;
      bus_req_r   <= bus_req_s;
      bus_we_r    <= bus_we_s;
      bus_addr_r  <= bus_addr_s;
      bus_wdata_r <= bus_wdata_s;
      new_sr_r    <= new_sr_s;
      new_ssp_r   <= new_ssp_s;
      load_r      <= load_s;
      busy_r      <= busy_s;
      halted_r    <= halted_s;
    end
  end

  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign new_pc    = fpc_r;
  assign new_sr    = new_sr_r;
  assign new_ssp   = new_ssp_r;
  assign pc_load   = load_r;
  assign sr_load   = load_r;
  assign ssp_load  = load_r;
  assign busy      = busy_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_mini68k_exc_sequencer.sv
// Directed, table-driven bench for mini68k_exc_sequencer with a small bus responder.
module tb_mini68k_exc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception_req;
  logic [7:0]  vector_num;
  logic        enter_supervisor;
  logic        exception_ack;
  logic [31:0] cur_pc;
  logic [15:0] cur_sr;
  logic [31:0] cur_ssp;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [15:0] bus_wdata, bus_rdata;
  logic        bus_ack, bus_err;
  logic [31:0] new_pc, new_ssp;
  logic [15:0] new_sr;
  logic        pc_load, sr_load, ssp_load, busy, halted;

  int checks = 0;
  int errors = 0;

  mini68k_exc_sequencer dut (
    .clk(clk), .rst(rst), .exception_req(exception_req), .vector_num(vector_num),
    .enter_supervisor(enter_supervisor), .exception_ack(exception_ack),
    .cur_pc(cur_pc), .cur_sr(cur_sr), .cur_ssp(cur_ssp),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .new_pc(new_pc), .new_sr(new_sr), .new_ssp(new_ssp),
    .pc_load(pc_load), .sr_load(sr_load), .ssp_load(ssp_load),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  vec;
    logic [31:0] pc;
    logic [15:0] sr;
    logic [31:0] ssp;
    logic        sup;
    int          waits;
    int          err_idx;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [31:0] e_pc;
    logic [15:0] e_sr;
    logic [31:0] e_ssp;
    int          e_cycle;
    logic        e_halt;
  } rec_t;

  rec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, {31'd0, exception_ack}, 32'd0);
    chk({tag, "_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus_we}, 32'd0);
    chk({tag, "_addr"}, bus_addr, 32'd0);
    chk({tag, "_wdata"}, {16'd0, bus_wdata}, 32'd0);
    chk({tag, "_new_pc"}, new_pc, 32'd0);
    chk({tag, "_new_sr"}, {16'd0, new_sr}, 32'd0);
    chk({tag, "_new_ssp"}, new_ssp, 32'd0);
    chk({tag, "_loads"}, {29'd0, pc_load, sr_load, ssp_load}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exception_req = 1'b0;
    bus_ack = 1'b0;
    bus_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one exception sequence with a wait-state bus responder and checks it.
  task automatic run_rec(input rec_t r, input int idx);
    int cyc, xfer, wcnt, load_cyc;
    bit done, halted_seen, ewe;
    logic [31:0] va, eaddr;
    logic [15:0] ewd;
    string tag;
    tag = $sformatf("rec%0d", idx);
    va = {22'd0, r.vec, 2'b00};
    @(negedge clk);
    exception_req = 1'b1; vector_num = r.vec; cur_pc = r.pc; cur_sr = r.sr;
    cur_ssp = r.ssp; enter_supervisor = r.sup;
    #1;
    chk({tag, "_ack0"}, {31'd0, exception_ack}, 32'd1);
    @(negedge clk);
    exception_req = 1'b0; vector_num = 8'd0; cur_pc = ~r.pc; cur_sr = ~r.sr;
    cur_ssp = ~r.ssp; enter_supervisor = ~r.sup;
    xfer = 0; wcnt = 0; load_cyc = -1; done = 1'b0; halted_seen = 1'b0;
    for (cyc = 1; cyc < 60 && !done; cyc++) begin
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 16'd0;
      if (halted) begin
        halted_seen = 1'b1;
        done = 1'b1;
        chk({tag, "_halt_noreq"}, {31'd0, bus_req}, 32'd0);
        chk({tag, "_halt_noload"}, {31'd0, pc_load}, 32'd0);
      end else if (pc_load) begin
        load_cyc = cyc;
        done = 1'b1;
        chk({tag, "_new_pc"}, new_pc, r.e_pc);
        chk({tag, "_new_sr"}, {16'd0, new_sr}, {16'd0, r.e_sr});
        chk({tag, "_new_ssp"}, new_ssp, r.e_ssp);
        chk({tag, "_sr_ssp_load"}, {30'd0, sr_load, ssp_load}, 32'd3);
      end else if (bus_req) begin
        case (xfer)
          0: begin eaddr = r.ssp - 32'd2; ewe = 1'b1; ewd = r.pc[15:0]; end
          1: begin eaddr = r.ssp - 32'd4; ewe = 1'b1; ewd = r.pc[31:16]; end
          2: begin eaddr = r.ssp - 32'd6; ewe = 1'b1; ewd = r.sr; end
          3: begin eaddr = va; ewe = 1'b0; ewd = 16'd0; end
          4: begin eaddr = va + 32'd2; ewe = 1'b0; ewd = 16'd0; end
          default: begin eaddr = 32'hFFFF_FFFF; ewe = 1'b0; ewd = 16'd0; end
        endcase
        chk($sformatf("%s_x%0d_addr", tag, xfer), bus_addr, eaddr);
        chk($sformatf("%s_x%0d_we", tag, xfer), {31'd0, bus_we}, {31'd0, ewe});
        if (ewe) chk($sformatf("%s_x%0d_wdata", tag, xfer), {16'd0, bus_wdata}, {16'd0, ewd});
        if (wcnt == r.waits) begin
          bus_ack = 1'b1;
          if (xfer == r.err_idx) bus_err = 1'b1;
          bus_rdata = (xfer == 3) ? r.hi : r.lo;
          xfer++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (!done) @(negedge clk);
    end
    bus_ack = 1'b0; bus_err = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_load_cycle"}, load_cyc, r.e_cycle);
    chk({tag, "_halted"}, {31'd0, halted_seen}, {31'd0, r.e_halt});
    if (r.e_halt) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        exception_req = 1'b1; vector_num = 8'd4;
        #1;
        chk({tag, "_halt_ignore_ack"}, {31'd0, exception_ack}, 32'd0);
        chk({tag, "_halt_stay"}, {30'd0, halted, bus_req}, 32'd2);
      end
      do_reset();
      #1;
      check_zero({tag, "_post_rst"});
    end else begin
      @(negedge clk);
      chk({tag, "_load_one_cycle"}, {31'd0, pc_load}, 32'd0);
      chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; exception_req = 1'b0; vector_num = 8'd0; enter_supervisor = 1'b0;
    cur_pc = 32'd0; cur_sr = 16'd0; cur_ssp = 32'd0;
    bus_rdata = 16'd0; bus_ack = 1'b0; bus_err = 1'b0;

    tbl[0] = '{vec:8'd4,  pc:32'h0000_1234, sr:16'h0700, ssp:32'h0000_1000, sup:1'b1, waits:0, err_idx:-1,
               hi:16'h0000, lo:16'h2000, e_pc:32'h0000_2000, e_sr:16'h2700, e_ssp:32'h0000_0FFA, e_cycle:6, e_halt:1'b0};
    tbl[1] = '{vec:8'd29, pc:32'h00AB_CDE0, sr:16'h8200, ssp:32'h0000_2000, sup:1'b1, waits:0, err_idx:-1,
               hi:16'h0001, lo:16'h0400, e_pc:32'h0001_0400, e_sr:16'h2500, e_ssp:32'h0000_1FFA, e_cycle:6, e_halt:1'b0};
    tbl[2] = '{vec:8'd30, pc:32'h1111_2222, sr:16'h8200, ssp:32'h0000_0004, sup:1'b0, waits:3, err_idx:-1,
               hi:16'h0000, lo:16'h3000, e_pc:32'h0000_3000, e_sr:16'h0600, e_ssp:32'hFFFF_FFFE, e_cycle:21, e_halt:1'b0};
    tbl[3] = '{vec:8'd24, pc:32'h0000_0400, sr:16'h2300, ssp:32'h0000_8000, sup:1'b0, waits:1, err_idx:-1,
               hi:16'hABCD, lo:16'h0010, e_pc:32'hABCD_0010, e_sr:16'h2300, e_ssp:32'h0000_7FFA, e_cycle:11, e_halt:1'b0};
    tbl[4] = '{vec:8'd31, pc:32'hFFFF_FFFE, sr:16'hA000, ssp:32'h0000_0100, sup:1'b0, waits:0, err_idx:-1,
               hi:16'h0000, lo:16'h0100, e_pc:32'h0000_0100, e_sr:16'h2700, e_ssp:32'h0000_00FA, e_cycle:6, e_halt:1'b0};
    tbl[5] = '{vec:8'd32, pc:32'h0000_0ABC, sr:16'h0712, ssp:32'h0000_3000, sup:1'b0, waits:2, err_idx:-1,
               hi:16'h0001, lo:16'h0000, e_pc:32'h0001_0000, e_sr:16'h0712, e_ssp:32'h0000_2FFA, e_cycle:16, e_halt:1'b0};
    tbl[6] = '{vec:8'd4,  pc:32'h0000_1234, sr:16'h0700, ssp:32'h0000_1000, sup:1'b1, waits:0, err_idx:-1,
               hi:16'h0000, lo:16'h2001, e_pc:32'h0, e_sr:16'h0, e_ssp:32'h0, e_cycle:-1, e_halt:1'b1};
    tbl[7] = '{vec:8'd5,  pc:32'h0000_5678, sr:16'h0000, ssp:32'h0000_4000, sup:1'b1, waits:1, err_idx:1,
               hi:16'h0000, lo:16'h0000, e_pc:32'h0, e_sr:16'h0, e_ssp:32'h0, e_cycle:-1, e_halt:1'b1};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("reset");

    for (int i = 0; i < 8; i++) run_rec(tbl[i], i);

    // exception_req held high: acks only at cycles 0, 7 and 14.
    begin
      int nack;
      nack = 0;
      @(negedge clk);
      exception_req = 1'b1; vector_num = 8'd4; cur_pc = 32'h0000_1234;
      cur_sr = 16'h0700; cur_ssp = 32'h0000_1000; enter_supervisor = 1'b1;
      for (int c = 0; c < 16; c++) begin
        #1;
        if (exception_ack) begin
          nack++;
          chk($sformatf("held_ack_at_%0d", c), c % 7, 32'd0);
        end
        bus_ack = bus_req;
        bus_rdata = (bus_addr == 32'h0000_0012) ? 16'h2000 : 16'h0000;
        @(negedge clk);
      end
      chk("held_ack_count", nack, 32'd3);
      do_reset();
      #1;
      check_zero("held_rst");
    end

    // Reset during FETCH_VL abandons the transfer.
    begin
      @(negedge clk);
      exception_req = 1'b1; vector_num = 8'd4;
      @(negedge clk);
      exception_req = 1'b0;
      for (int c = 1; c < 5; c++) begin
        bus_ack = bus_req;
        bus_rdata = 16'h0000;
        @(negedge clk);
      end
      bus_ack = 1'b0;
      chk("fvl_addr", bus_addr, 32'h0000_0012);
      chk("fvl_req", {31'd0, bus_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_zero("fvl_rst");
      @(negedge clk);
      chk("fvl_after_req", {30'd0, bus_req, busy}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
